// File: rtl/fft_x4_input_collector.sv
// rtl/fft_x4_input_collector.sv - serial-to-parallel 4-sample loader for the radix-4 butterfly
//
// Collects one complex sample per accepted cycle into groups of four (slot 0 =
// oldest) and presents each group for exactly one cycle on o_valid. Each sample
// is arithmetically right-shifted by SHIFT on entry so the butterfly's 4-point
// sum cannot wrap. A frame may end early (i_last before slot 3); the missing
// slots are then zero-padded and o_short is raised.
//
// Ports:
//   i_clk, i_rst_n         clock (rising edge), asynchronous active-low reset
//   i_flush                synchronous discard of the partial group, resets frame count
//   i_valid                input sample valid (no backpressure)
//   i_data_i, i_data_q     input sample real / imaginary part
//   i_last                 last sample of frame, qualified by i_valid
//   o_valid                one-cycle pulse: o_dataN_* hold a new group
//   o_data0_i..o_data3_q   slot 0..3 real / imaginary parts, held between groups
//   o_last                 pulse: group contains the frame's last sample
//   o_short                pulse: group was zero-padded
//   o_group_cnt            index of the emitted group within its frame, held

module fft_x4_input_collector #(
   parameter int SIZE_DATA = 16,
   parameter int SHIFT     = 0,
   parameter int CNT_W     = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_flush,
   input  logic                 i_valid,
   input  logic [SIZE_DATA-1:0] i_data_i,
   input  logic [SIZE_DATA-1:0] i_data_q,
   input  logic                 i_last,
   output logic                 o_valid,
   output logic [SIZE_DATA-1:0] o_data0_i,
   output logic [SIZE_DATA-1:0] o_data0_q,
   output logic [SIZE_DATA-1:0] o_data1_i,
   output logic [SIZE_DATA-1:0] o_data1_q,
   output logic [SIZE_DATA-1:0] o_data2_i,
   output logic [SIZE_DATA-1:0] o_data2_q,
   output logic [SIZE_DATA-1:0] o_data3_i,
   output logic [SIZE_DATA-1:0] o_data3_q,
   output logic                 o_last,
   output logic                 o_short,
   output logic [CNT_W-1:0]     o_group_cnt
);

   // Pre-scaled current sample (floor division by 2^SHIFT, width preserved)
   logic signed [SIZE_DATA-1:0] smp_i;
   logic signed [SIZE_DATA-1:0] smp_q;

   assign smp_i = $signed(i_data_i) >>> SHIFT;
   assign smp_q = $signed(i_data_q) >>> SHIFT;

   // Staging has four entries so the slot index never leaves the array;
   // entry 3 is never written because slot 3 always completes a group.
   logic [SIZE_DATA-1:0] stg_i [4];
   logic [SIZE_DATA-1:0] stg_q [4];
   logic [SIZE_DATA-1:0] out_i [4];
   logic [SIZE_DATA-1:0] out_q [4];
   logic [1:0]           slot;
   logic [CNT_W-1:0]     grp_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int j = 0; j < 4; j++) begin
            stg_i[j] <= '0;
            stg_q[j] <= '0;
            out_i[j] <= '0;
            out_q[j] <= '0;
         end
         slot        <= 2'd0;
         grp_cnt     <= '0;
         o_valid     <= 1'b0;
         o_last      <= 1'b0;
         o_short     <= 1'b0;
         o_group_cnt <= '0;
      end else begin
         o_valid <= 1'b0;
         o_last  <= 1'b0;
         o_short <= 1'b0;
         if (i_flush) begin
            // Flush beats a simultaneous sample; stale staging is simply
            // overwritten by the next group.
            slot    <= 2'd0;
            grp_cnt <= '0;
         end else if (i_valid) begin
            if (slot == 2'd3 || i_last) begin
               for (int j = 0; j < 4; j++) begin
                  if (2'(j) < slot) begin
                     out_i[j] <= stg_i[j];
                     out_q[j] <= stg_q[j];
                  end else if (2'(j) == slot) begin
                     out_i[j] <= smp_i;
                     out_q[j] <= smp_q;
                  end else begin
                     out_i[j] <= '0;
                     out_q[j] <= '0;
                  end
               end
               o_valid     <= 1'b1;
               o_last      <= i_last;
               o_short     <= i_last && (slot != 2'd3);
               o_group_cnt <= grp_cnt;
               grp_cnt     <= i_last ? '0 : grp_cnt + CNT_W'(1);
               slot        <= 2'd0;
            end else begin
               stg_i[slot] <= smp_i;
               stg_q[slot] <= smp_q;
               slot        <= slot + 2'd1;
            end
         end
      end
   end

   assign o_data0_i = out_i[0];
   assign o_data0_q = out_q[0];
   assign o_data1_i = out_i[1];
   assign o_data1_q = out_q[1];
   assign o_data2_i = out_i[2];
   assign o_data2_q = out_q[2];
   assign o_data3_i = out_i[3];
   assign o_data3_q = out_q[3];

endmodule

// File: tb/tb_fft_x4_input_collector.sv
// tb/tb_fft_x4_input_collector.sv - scoreboard bench for fft_x4_input_collector
//
// Two instances share one stimulus stream: SHIFT=0 and SHIFT=2. A frame-level
// reference model turns every issued sample into expected groups pushed onto
// per-instance queues; a negedge monitor pops and compares whenever o_valid is
// seen and checks that outputs hold (and pulses stay low) otherwise.

module tb_fft_x4_input_collector;

   typedef struct {
      logic [3:0][15:0] di;
      logic [3:0][15:0] dq;
      logic             last;
      logic             shrt;
      logic [7:0]       cnt;
      int               cyc;
   } grp_t;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        valid;
   logic [15:0] din_i;
   logic [15:0] din_q;
   logic        last;

   logic        v0, l0, s0, v1, l1, s1;
   logic [15:0] a0i0, a0q0, a0i1, a0q1, a0i2, a0q2, a0i3, a0q3;
   logic [15:0] a1i0, a1q0, a1i1, a1q1, a1i2, a1q2, a1i3, a1q3;
   logic [7:0]  c0, c1;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   grp_t exp_q0[$];
   grp_t exp_q1[$];
   grp_t last_e[2];

   // Reference model state: raw samples of the open group and frame group index
   logic [15:0] pend_i[$];
   logic [15:0] pend_q[$];
   logic [7:0]  frame_cnt;

   fft_x4_input_collector #(.SIZE_DATA(16), .SHIFT(0), .CNT_W(8)) dut0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(valid),
      .i_data_i(din_i), .i_data_q(din_q), .i_last(last),
      .o_valid(v0),
      .o_data0_i(a0i0), .o_data0_q(a0q0), .o_data1_i(a0i1), .o_data1_q(a0q1),
      .o_data2_i(a0i2), .o_data2_q(a0q2), .o_data3_i(a0i3), .o_data3_q(a0q3),
      .o_last(l0), .o_short(s0), .o_group_cnt(c0)
   );

   fft_x4_input_collector #(.SIZE_DATA(16), .SHIFT(2), .CNT_W(8)) dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(valid),
      .i_data_i(din_i), .i_data_q(din_q), .i_last(last),
      .o_valid(v1),
      .o_data0_i(a1i0), .o_data0_q(a1q0), .o_data1_i(a1i1), .o_data1_q(a1q1),
      .o_data2_i(a1i2), .o_data2_q(a1q2), .o_data3_i(a1i3), .o_data3_q(a1q3),
      .o_last(l1), .o_short(s1), .o_group_cnt(c1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Floor division by 2^sh using plain integer arithmetic
   function automatic logic [15:0] scale(input logic [15:0] x, input int sh);
      int v, dv, r;
      v  = $signed(x);
      dv = 1 << sh;
      r  = v % dv;
      if (r < 0) r += dv;
      return 16'((v - r) / dv);
   endfunction

   function automatic grp_t build(input int sh, input logic l);
      grp_t g;
      for (int j = 0; j < 4; j++) begin
         if (j < pend_i.size()) begin
            g.di[j] = scale(pend_i[j], sh);
            g.dq[j] = scale(pend_q[j], sh);
         end else begin
            g.di[j] = 16'h0;
            g.dq[j] = 16'h0;
         end
      end
      g.last = l;
      g.shrt = l && (pend_i.size() < 4);
      g.cnt  = frame_cnt;
      g.cyc  = cyc + 1;
      return g;
   endfunction

   task automatic model_step(input logic v, input logic l, input logic f,
                             input logic [15:0] di, input logic [15:0] dq);
      if (f) begin
         pend_i.delete();
         pend_q.delete();
         frame_cnt = 8'd0;
      end else if (v) begin
         pend_i.push_back(di);
         pend_q.push_back(dq);
         if (pend_i.size() == 4 || l) begin
            exp_q0.push_back(build(0, l));
            exp_q1.push_back(build(2, l));
            frame_cnt = l ? 8'd0 : frame_cnt + 8'd1;
            pend_i.delete();
            pend_q.delete();
         end
      end
   endtask

   task automatic model_reset();
      grp_t z;
      z.di = '0; z.dq = '0; z.last = 1'b0; z.shrt = 1'b0; z.cnt = 8'd0; z.cyc = 0;
      pend_i.delete();
      pend_q.delete();
      frame_cnt = 8'd0;
      exp_q0.delete();
      exp_q1.delete();
      last_e[0] = z;
      last_e[1] = z;
   endtask

   task automatic drive(input logic v, input logic l, input logic f,
                        input logic [15:0] di, input logic [15:0] dq);
      @(posedge clk);
      #1;
      valid = v; last = l; flush = f; din_i = di; din_q = dq;
      model_step(v, l, f, di, dq);
   endtask

   task automatic check_dut(input int d, input logic v, input logic l, input logic s,
                            input logic [3:0][15:0] ai, input logic [3:0][15:0] aq,
                            input logic [7:0] c);
      grp_t e;
      if (v) begin
         checks++;
         if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
            errors++;
            $display("FAIL unexpected_valid dut%0d cyc %0d: got o_valid=1, expected no group", d, cyc);
         end else begin
            e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            if (ai !== e.di || aq !== e.dq || l !== e.last || s !== e.shrt ||
                c !== e.cnt || cyc != e.cyc) begin
               errors++;
               $display("FAIL group dut%0d: got i=%h q=%h last=%0b short=%0b cnt=%0d cyc=%0d, expected i=%h q=%h last=%0b short=%0b cnt=%0d cyc=%0d",
                        d, ai, aq, l, s, c, cyc, e.di, e.dq, e.last, e.shrt, e.cnt, e.cyc);
            end
            last_e[d] = e;
         end
      end else begin
         checks++;
         if (l !== 1'b0 || s !== 1'b0 || ai !== last_e[d].di || aq !== last_e[d].dq ||
             c !== last_e[d].cnt) begin
            errors++;
            $display("FAIL hold dut%0d cyc %0d: got i=%h q=%h last=%0b short=%0b cnt=%0d, expected i=%h q=%h last=0 short=0 cnt=%0d",
                     d, cyc, ai, aq, l, s, c, last_e[d].di, last_e[d].dq, last_e[d].cnt);
         end
      end
   endtask

   always @(negedge clk) begin
      check_dut(0, v0, l0, s0, {a0i3, a0i2, a0i1, a0i0}, {a0q3, a0q2, a0q1, a0q0}, c0);
      check_dut(1, v1, l1, s1, {a1i3, a1i2, a1i1, a1i0}, {a1q3, a1q2, a1q1, a1q0}, c1);
   end

   task automatic check_reset(input string name);
      logic [255:0] all;
      all = {v0, l0, s0, c0, a0i0, a0q0, a0i1, a0q1, a0i2, a0q2, a0i3, a0q3,
             v1, l1, s1, c1, a1i0, a1q0, a1i1, a1q1, a1i2, a1q2, a1i3, a1q3};
      checks++;
      if (all !== '0) begin
         errors++;
         $display("FAIL %s: got outputs %h, expected all zero", name, all);
      end
   endtask

   task automatic reset_now(input string name);
      @(posedge clk);
      #1;
      valid = 1'b0; last = 1'b0; flush = 1'b0;
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_reset(name);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      valid = 1'b0; last = 1'b0; flush = 1'b0; din_i = '0; din_q = '0;
      rst_n = 1'b1;
      model_reset();
      #1 rst_n = 1'b0;
      #1 check_reset("reset_initial");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Full rate: samples 1..8, q = -1..-8
      for (int n = 1; n <= 8; n++) drive(1, 0, 0, 16'(n), 16'(-n));
      drive(0, 0, 0, 0, 0);

      // Short frame: 10, 20 with last, then a full group that must restart at cnt 0
      drive(1, 0, 0, 16'd10, 16'd11);
      drive(1, 1, 0, 16'd20, 16'd21);
      for (int n = 0; n < 4; n++) drive(1, 0, 0, 16'(100 + n), 16'(200 + n));

      // Scaling corner values, visible through the SHIFT=2 instance
      drive(1, 0, 0, 16'hfffb, 16'h0007);
      drive(1, 0, 0, 16'h0007, 16'hfffb);
      drive(1, 0, 0, 16'h8000, 16'h7fff);
      drive(1, 1, 0, 16'h7fff, 16'h8000);

      // Flush after three samples, with a simultaneous valid that must be dropped
      for (int n = 0; n < 3; n++) drive(1, 0, 0, 16'(30 + n), 16'(40 + n));
      drive(1, 1, 1, 16'd99, 16'd99);
      for (int n = 0; n < 4; n++) drive(1, 0, 0, 16'(50 + n), 16'(60 + n));

      // Gapped input: valid on alternate cycles
      for (int n = 0; n < 8; n++) begin
         drive(1, 0, 0, 16'(70 + n), 16'(80 + n));
         drive(0, 1, 0, 16'hdead, 16'hbeef);
      end

      // i_last on slot 3 (full group, not short); single-sample frame
      for (int n = 0; n < 4; n++) drive(1, n == 3, 0, 16'(90 + n), 16'(95 + n));
      drive(1, 1, 0, 16'h1234, 16'h5678);

      // Reset mid-group discards the partial samples
      drive(1, 0, 0, 16'h0aaa, 16'h0bbb);
      drive(1, 0, 0, 16'h0ccc, 16'h0ddd);
      reset_now("reset_mid_group");
      for (int n = 0; n < 4; n++) drive(1, 0, 0, 16'(7 + n), 16'(-7 - n));

      // Randomized traffic
      for (int n = 0; n < 600; n++)
         drive($urandom_range(0, 9) < 7, $urandom_range(0, 7) == 0,
               $urandom_range(0, 29) == 0, 16'($urandom), 16'($urandom));

      for (int n = 0; n < 4; n++) drive(0, 0, 0, 0, 0);

      checks++;
      if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d/%0d groups never emitted, expected 0/0",
                  exp_q0.size(), exp_q1.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
